// File: rtl/spec_history_fifo.sv
// spec_history_fifo: speculative global branch-history register with a
// circular checkpoint buffer. Predicts shift in the predicted outcome and
// save the pre-shift history. Mispredicts restore from the checkpoint and
// flush younger checkpoints. Retire frees the oldest checkpoint.
// Optional feature macro: SPEC_HIST_STATS_EN adds mispredict/drop counters.
module spec_history_fifo #(
  parameter int N          = 64,
  parameter int CKPT_DEPTH = 8,
  parameter int PTR_W      = $clog2(CKPT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic [PTR_W-1:0] pred_tag,
  input  logic             resolve_valid,
  input  logic             mispredict_valid,
  input  logic [PTR_W-1:0] mispredict_tag,
  input  logic             mispredict_taken,
  output logic [N-1:0]     hist_out,
  output logic [PTR_W:0]   ckpt_count,
  output logic             ckpt_full,
  output logic             ckpt_empty
`ifdef SPEC_HIST_STATS_EN
  ,
  output logic [31:0]      stat_mispredicts,
  output logic [31:0]      stat_drops
`endif
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = CKPT_DEPTH[PTR_W:0];

  logic [N-1:0]     hist;
  logic [N-1:0]     ckpt [CKPT_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic [PTR_W-1:0] mp_dist;
  logic             mp_ok;
  logic             pred_ok;
  logic             retire;

  // Classify this cycle's requests against the pre-cycle pointers.
  always_comb begin
    mp_dist = mispredict_tag - head;
    mp_ok   = mispredict_valid && ({1'b0, mp_dist} < count);
    retire  = resolve_valid && (count != '0);
    pred_ok = pred_valid && !ckpt_full && !mispredict_valid;
  end

  // History, pointers and occupancy; mispredict restore takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire)
        head <= head + PTR_ONE;
      if (mp_ok) begin
        hist  <= {ckpt[mispredict_tag][N-2:0], mispredict_taken};
        tail  <= mispredict_tag + PTR_ONE;
        // Mispredicted branch keeps its slot unless it also retires now.
        count <= retire ? {1'b0, mp_dist} : ({1'b0, mp_dist} + CNT_ONE);
      end else begin
        if (pred_ok) begin
          hist <= {hist[N-2:0], pred_taken};
          tail <= tail + PTR_ONE;
        end
        if (pred_ok && !retire)
          count <= count + CNT_ONE;
        else if (!pred_ok && retire)
          count <= count - CNT_ONE;
      end
    end
  end

  // Checkpoint storage needs no reset; only in-flight slots are ever read.
  always_ff @(posedge clk) begin
    if (!rst && !mp_ok && pred_ok)
      ckpt[tail] <= hist;
  end

`ifdef SPEC_HIST_STATS_EN
  // Saturating event counters for valid mispredicts and full-buffer drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_mispredicts <= '0;
      stat_drops       <= '0;
    end else begin
      if (mp_ok && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
      if (pred_valid && ckpt_full && !mispredict_valid && stat_drops != 32'hFFFF_FFFF)
        stat_drops <= stat_drops + 32'd1;
    end
  end
`endif

  // Outputs are pure functions of the registered state.
  always_comb begin
    pred_tag   = tail;
    hist_out   = hist;
    ckpt_count = count;
    ckpt_full  = (count == CNT_MAX);
    ckpt_empty = (count == '0);
  end

endmodule

// File: doc/spec_history_fifo.md
Name: spec_history_fifo

Overview:
- Speculative global branch-history shift register with checkpoint/restore, generalising the plain 1-bit history FIFO.
- Each predicted branch shifts its predicted outcome into the history and saves a checkpoint of the pre-shift history in a circular checkpoint buffer.
- A mispredict restores the history from the checkpoint, shifts in the corrected outcome and flushes younger checkpoints; retire frees the oldest checkpoint.
- Sits between the front-end predictor (history consumer) and the branch resolution/retire logic.

Parameters:
- N, 64, history length in bits (>=2).
- CKPT_DEPTH, 8, number of in-flight checkpoints; power of 2, >=2.
- PTR_W, $clog2(CKPT_DEPTH), checkpoint tag width (derived; do not override).

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- pred_valid  input  1  new predicted branch this cycle.
- pred_taken  input  1  predicted outcome.
- pred_tag  output  PTR_W  tag allocated to a pred_valid this cycle; combinational, equals tail pointer.
- resolve_valid  input  1  oldest in-flight branch retires; frees head checkpoint.
- mispredict_valid  input  1  a branch resolved as mispredicted.
- mispredict_tag  input  PTR_W  tag of the mispredicted branch.
- mispredict_taken  input  1  corrected outcome.
- hist_out  output  N  current speculative history; bit 0 newest, bit N-1 oldest.
- ckpt_count  output  PTR_W+1  in-flight checkpoints, 0..CKPT_DEPTH.
- ckpt_full  output  1  ckpt_count == CKPT_DEPTH.
- ckpt_empty  output  1  ckpt_count == 0.

Behaviour:
- Reset: hist_out=0, head=tail=0, ckpt_count=0, ckpt_empty=1, ckpt_full=0; checkpoint storage contents don't-care.
- The history, head, tail and count registers change only on posedge clk. All outputs are functions of these registers, so every effect is visible 1 cycle after the input.
- Accepted predict (pred_valid & !ckpt_full & !mispredict_valid):
  - ckpt[tail] <= hist.
  - hist <= {hist[N-2:0], pred_taken}.
  - tail <= tail+1, wrapping mod CKPT_DEPTH.
  - count +1.
- Predict while ckpt_full: dropped. No shift, no allocation. pred_tag is don't-care.
- Valid mispredict:
  - Valid means mispredict_tag is in flight, i.e. (mispredict_tag - head) mod CKPT_DEPTH < ckpt_count.
  - hist <= {ckpt[tag][N-2:0], mispredict_taken}.
  - tail <= tag+1.
  - count <= ((tag - head) mod CKPT_DEPTH) + 1.
  - The mispredicted branch keeps its checkpoint; all younger checkpoints are flushed.
- Invalid mispredict (tag not in flight, or count==0): ignored entirely. It also blocks any pred_valid in the same cycle.
- Priority: mispredict beats predict in the same cycle, and the predict is discarded.
- Retire (resolve_valid & count>0): head <= head+1 and count -1. Does not touch hist. Retire with count==0 is ignored.
- Retire + accepted predict in the same cycle: count unchanged, both pointers advance.
- Retire + valid mispredict in the same cycle: apply both.
  - Final count = ((tag - head) mod CKPT_DEPTH) + 1 - 1, computed with the pre-cycle head.
  - If tag == head, the mispredicted branch also retires: count -> 0, hist still restored.
- Pointer wrap: tags wrap mod CKPT_DEPTH. Full vs empty is distinguished only by ckpt_count.
- Reset mid-operation: all in-flight checkpoints are discarded and the history is zeroed in the same cycle. Reset overrides all other inputs.

Optional Feature:
- Macro: SPEC_HIST_STATS_EN.
- Defined: adds output ports stat_mispredicts[31:0] and stat_drops[31:0].
  - stat_mispredicts counts valid mispredicts.
  - stat_drops counts predicts dropped due to ckpt_full.
  - Both saturate at 2^32-1 and clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 4 predicts taken=1,0,1,1 -> hist_out[3:0]=4'b1011, ckpt_count=4, pred_tag sequence 0,1,2,3.
- Continuing: mispredict tag=1, taken=1 -> hist_out[3:0]=4'b0011 (ckpt[1]=...01, then shift in 1), ckpt_count=2, next pred_tag=2.
- Fill 8 predicts (CKPT_DEPTH=8), 9th predict -> ckpt_full=1, hist_out unchanged, count=8. Under SPEC_HIST_STATS_EN, stat_drops=1.
- Retire + predict same cycle with count=8 -> predict dropped (full pre-cycle), count=7. Next cycle predict+retire -> count stays 7, tags wrap 7->0.
- Mispredict tag=head with resolve_valid same cycle, count=3 -> count=0, ckpt_empty=1, hist restored plus corrected bit. Mispredict with out-of-flight tag -> no change.
- N=4 after 5 predicts all 1 -> hist_out=4'b1111; assert rst mid-stream -> next cycle hist_out=0, count=0, pred_tag=0.
